// File: rtl/reg_slice_pkg.sv
// rtl/reg_slice_pkg.sv - shared mode encodings and parameter helpers for the register slice chain
package reg_slice_pkg;

    localparam int MODE_FWD    = 0;
    localparam int MODE_FULL   = 1;
    localparam int MODE_BYPASS = 2;

    localparam int DW_MAX    = 1024;
    localparam int DEPTH_MAX = 8;

    // Beats one stage can hold in the given mode.
    function automatic int stage_capacity(input int mode);
        if (mode == MODE_FULL) begin
            return 2;
        end
        if (mode == MODE_FWD) begin
            return 1;
        end
        return 0;
    endfunction

    // DEPTH does not matter in bypass mode, so it is only range-checked otherwise.
    function automatic bit params_legal(input int dw, input int depth, input int mode);
        bit ok;
        ok = (dw >= 1) && (dw <= DW_MAX);
        ok = ok && (mode >= MODE_FWD) && (mode <= MODE_BYPASS);
        if (mode != MODE_BYPASS) begin
            ok = ok && (depth >= 1) && (depth <= DEPTH_MAX);
        end
        return ok;
    endfunction

endpackage

// File: rtl/reg_slice_stage.sv
// rtl/reg_slice_stage.sv - one valid/ready register slice, forward-registered or fully registered skid buffer
module reg_slice_stage
    import reg_slice_pkg::*;
#(
    parameter int DW   = 16,
    parameter int MODE = MODE_FWD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    input  logic [DW-1:0] up_data,
    output logic          up_ready,
    output logic          down_valid,
    output logic [DW-1:0] down_data,
    input  logic          down_ready,
    output logic [1:0]    fill
);

    generate
        if (MODE == MODE_FWD) begin : g_fwd
            logic          run_q;
            logic          valid_q;
            logic [DW-1:0] data_q;

            // Holds up_ready low while in reset and until the first edge after release.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    run_q <= 1'b0;
                end else begin
                    run_q <= 1'b1;
                end
            end

            // Ready passes straight through from downstream when the register is occupied.
            assign up_ready = run_q && (!valid_q || down_ready);

            // Capture a new beat (or a bubble) whenever the slot is free or draining.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else if (up_ready) begin
                    valid_q <= up_valid;
                    if (up_valid) begin
                        data_q <= up_data;
                    end
                end
            end

            assign down_valid = valid_q;
            assign down_data  = data_q;
            assign fill       = {1'b0, valid_q};
        end else if (MODE == MODE_FULL) begin : g_full
            logic          ready_q;
            logic          main_valid;
            logic          skid_valid;
            logic [DW-1:0] main_data;
            logic [DW-1:0] skid_data;
            logic          main_valid_d;
            logic          skid_valid_d;
            logic          load_from_skid;
            logic          load_from_up;
            logic          load_skid;
            logic          up_xfer;
            logic          main_free;

            // ready_q is registered, so neither handshake input reaches an output combinationally.
            assign up_xfer   = up_valid && ready_q;
            assign main_free = !main_valid || down_ready;

            // Next occupancy of main/skid: skid refills main first, otherwise an arriving
            // beat lands in main if it can move, else parks in skid.
            always_comb begin
                main_valid_d   = main_valid;
                skid_valid_d   = skid_valid;
                load_from_skid = 1'b0;
                load_from_up   = 1'b0;
                load_skid      = 1'b0;
                if (main_free) begin
                    if (skid_valid) begin
                        main_valid_d   = 1'b1;
                        skid_valid_d   = 1'b0;
                        load_from_skid = 1'b1;
                    end else begin
                        main_valid_d = up_xfer;
                        load_from_up = up_xfer;
                    end
                end else if (up_xfer) begin
                    skid_valid_d = 1'b1;
                    load_skid    = 1'b1;
                end
            end

            // Register flags and payloads; data only moves when a beat enters that register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ready_q    <= 1'b0;
                    main_valid <= 1'b0;
                    skid_valid <= 1'b0;
                    main_data  <= '0;
                    skid_data  <= '0;
                end else begin
                    ready_q    <= !skid_valid_d;
                    main_valid <= main_valid_d;
                    skid_valid <= skid_valid_d;
                    if (load_from_skid) begin
                        main_data <= skid_data;
                    end else if (load_from_up) begin
                        main_data <= up_data;
                    end
                    if (load_skid) begin
                        skid_data <= up_data;
                    end
                end
            end

            assign up_ready   = ready_q;
            assign down_valid = main_valid;
            assign down_data  = main_data;
            assign fill       = {1'b0, main_valid} + {1'b0, skid_valid};
        end else begin : g_bad_mode
            $error("reg_slice_stage: MODE must be MODE_FWD or MODE_FULL");
        end
    endgenerate

endmodule

// File: rtl/reg_slice_chain.sv
// rtl/reg_slice_chain.sv - cascade of DEPTH register slices with occupancy count, or a pure bypass
module reg_slice_chain
    import reg_slice_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = 1,
    parameter int MODE  = MODE_FWD,
    parameter int CW    = $clog2(2 * DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    input  logic [DW-1:0] up_data,
    output logic          up_ready,
    output logic          down_valid,
    output logic [DW-1:0] down_data,
    input  logic          down_ready,
    output logic [CW-1:0] occupancy
);

    generate
        if (!params_legal(DW, DEPTH, MODE)) begin : g_bad_params
            $error("reg_slice_chain: DW, DEPTH or MODE out of range");
        end

        if (MODE == MODE_BYPASS) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;

            assign up_ready   = down_ready;
            assign down_valid = up_valid;
            assign down_data  = up_data;
            assign occupancy  = '0;
        end else begin : g_chain
            logic [DEPTH:0]            link_valid;
            logic [DEPTH:0]            link_ready;
            logic [DEPTH:0][DW-1:0]    link_data;
            logic [DEPTH-1:0][1:0]     stage_fill;
            logic [CW-1:0]             occ_sum;

            assign link_valid[0]     = up_valid;
            assign link_data[0]      = up_data;
            assign up_ready          = link_ready[0];
            assign down_valid        = link_valid[DEPTH];
            assign down_data         = link_data[DEPTH];
            assign link_ready[DEPTH] = down_ready;

            for (genvar k = 0; k < DEPTH; k++) begin : g_stage
                reg_slice_stage #(
                    .DW   (DW),
                    .MODE (MODE)
                ) u_stage (
                    .clk        (clk),
                    .rst        (rst),
                    .up_valid   (link_valid[k]),
                    .up_data    (link_data[k]),
                    .up_ready   (link_ready[k]),
                    .down_valid (link_valid[k+1]),
                    .down_data  (link_data[k+1]),
                    .down_ready (link_ready[k+1]),
                    .fill       (stage_fill[k])
                );
            end

            // Occupancy is the sum of beats held in every stage.
            always_comb begin
                occ_sum = '0;
                for (int k = 0; k < DEPTH; k++) begin
                    occ_sum = occ_sum + CW'(stage_fill[k]);
                end
            end

            assign occupancy = occ_sum;
        end
    endgenerate

endmodule

// File: tb/tb_reg_slice_chain.sv
// tb/tb_reg_slice_chain.sv - randomized and directed checks of reg_slice_chain in forward, full and bypass modes
module tb_reg_slice_chain;
    import reg_slice_pkg::*;

    localparam int DW = 16;
    localparam int F_DEPTH = 3;
    localparam int S_DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          f_up_valid = 1'b0, f_up_ready, f_down_valid, f_down_ready = 1'b0;
    logic [DW-1:0] f_up_data = '0, f_down_data;
    logic [2:0]    f_occ;

    logic          s_up_valid = 1'b0, s_up_ready, s_down_valid, s_down_ready = 1'b0;
    logic [DW-1:0] s_up_data = '0, s_down_data;
    logic [2:0]    s_occ;

    logic          b_up_valid = 1'b0, b_up_ready, b_down_valid, b_down_ready = 1'b0;
    logic [DW-1:0] b_up_data = '0, b_down_data;
    logic [1:0]    b_occ;

    int total = 0;
    int bad = 0;

    logic [DW-1:0] q_fwd[$];
    logic [DW-1:0] q_full[$];
    int unsigned   edges;
    logic          f_stall_prev, s_stall_prev;
    logic [DW-1:0] f_data_prev, s_data_prev;

    reg_slice_chain #(.DW(DW), .DEPTH(F_DEPTH), .MODE(MODE_FWD)) u_fwd (
        .clk(clk), .rst(rst),
        .up_valid(f_up_valid), .up_data(f_up_data), .up_ready(f_up_ready),
        .down_valid(f_down_valid), .down_data(f_down_data), .down_ready(f_down_ready),
        .occupancy(f_occ)
    );

    reg_slice_chain #(.DW(DW), .DEPTH(S_DEPTH), .MODE(MODE_FULL)) u_full (
        .clk(clk), .rst(rst),
        .up_valid(s_up_valid), .up_data(s_up_data), .up_ready(s_up_ready),
        .down_valid(s_down_valid), .down_data(s_down_data), .down_ready(s_down_ready),
        .occupancy(s_occ)
    );

    reg_slice_chain #(.DW(DW), .MODE(MODE_BYPASS)) u_byp (
        .clk(clk), .rst(rst),
        .up_valid(b_up_valid), .up_data(b_up_data), .up_ready(b_up_ready),
        .down_valid(b_down_valid), .down_data(b_down_data), .down_ready(b_down_ready),
        .occupancy(b_occ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Edges seen since reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) edges <= 0;
        else if (edges < 1000) edges <= edges + 1;
    end

    // Reference model: a beat queue per chain, updated from the handshakes seen each cycle.
    always @(negedge clk) begin
        chk("byp_valid", b_down_valid, b_up_valid);
        chk("byp_data", b_down_data, b_up_data);
        chk("byp_ready", b_up_ready, b_down_ready);
        chk("byp_occ", b_occ, 0);
        if (rst) begin
            q_fwd.delete();
            q_full.delete();
            f_stall_prev = 1'b0;
            s_stall_prev = 1'b0;
            chk("rst_fwd_occ", f_occ, 0);
            chk("rst_fwd_valid", f_down_valid, 0);
            chk("rst_fwd_ready", f_up_ready, 0);
            chk("rst_full_occ", s_occ, 0);
            chk("rst_full_valid", s_down_valid, 0);
            chk("rst_full_ready", s_up_ready, 0);
        end else begin
            // forward chain
            chk("fwd_occ", f_occ, q_fwd.size());
            if (edges == 0) chk("fwd_ready_release", f_up_ready, 0);
            else chk("fwd_ready_rule", f_up_ready, (q_fwd.size() < F_DEPTH) || f_down_ready);
            if (f_stall_prev) begin
                chk("fwd_stall_valid", f_down_valid, 1);
                chk("fwd_stall_data", f_down_data, f_data_prev);
            end
            if (f_down_valid) begin
                chk("fwd_nonempty", q_fwd.size() != 0, 1);
                if (q_fwd.size() != 0) chk("fwd_data", f_down_data, q_fwd[0]);
            end
            if (f_down_valid && f_down_ready && q_fwd.size() != 0) void'(q_fwd.pop_front());
            if (f_up_valid && f_up_ready) q_fwd.push_back(f_up_data);
            chk("fwd_cap", q_fwd.size() <= F_DEPTH, 1);
            f_stall_prev = f_down_valid && !f_down_ready;
            f_data_prev  = f_down_data;

            // full (skid) chain
            chk("full_occ", s_occ, q_full.size());
            if (edges == 0) chk("full_ready_release", s_up_ready, 0);
            else begin
                if (q_full.size() == 2 * S_DEPTH) chk("full_ready_at_cap", s_up_ready, 0);
                if (!s_up_ready) chk("full_ready_low_occ", q_full.size() >= 2, 1);
            end
            if (s_stall_prev) begin
                chk("full_stall_valid", s_down_valid, 1);
                chk("full_stall_data", s_down_data, s_data_prev);
            end
            if (s_down_valid) begin
                chk("full_nonempty", q_full.size() != 0, 1);
                if (q_full.size() != 0) chk("full_data", s_down_data, q_full[0]);
            end
            if (s_down_valid && s_down_ready && q_full.size() != 0) void'(q_full.pop_front());
            if (s_up_valid && s_up_ready) q_full.push_back(s_up_data);
            chk("full_cap", q_full.size() <= 2 * S_DEPTH, 1);
            s_stall_prev = s_down_valid && !s_down_ready;
            s_data_prev  = s_down_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int first_acc, first_out, acc_n, fourth, low_at, stale, emits;
        int out_cyc[$];
        logic [DW-1:0] out_dat[$];
        logic acc;
        logic ur0, dv0;
        logic [DW-1:0] dd0;
        logic [2:0] oc0;
        int rp;

        // reset state
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("reset_fwd_occ", f_occ, 0);
        chk("reset_fwd_valid", f_down_valid, 0);
        chk("reset_fwd_ready", f_up_ready, 0);
        chk("reset_full_ready", s_up_ready, 0);
        rst = 1'b0;
        cyc();
        chk("release_fwd_ready", f_up_ready, 1);
        chk("release_full_ready", s_up_ready, 1);

        // forward DEPTH=3: five back-to-back beats, latency 3, one per cycle
        f_down_ready = 1'b1;
        f_up_valid   = 1'b1;
        f_up_data    = 16'h0001;
        first_acc = -1;
        first_out = -1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            acc = f_up_valid && f_up_ready;
            if (acc && first_acc < 0) first_acc = c;
            if (f_down_valid) begin
                if (first_out < 0) first_out = c;
                out_cyc.push_back(c);
                out_dat.push_back(f_down_data);
            end
            cyc();
            if (acc) begin
                if (f_up_data == 16'h0005) f_up_valid = 1'b0;
                else f_up_data = f_up_data + 16'h1;
            end
        end
        chk("lat_first_acc", first_acc, 0);
        chk("lat_latency", first_out - first_acc, 3);
        chk("lat_count", out_dat.size(), 5);
        for (int i = 0; i < out_dat.size() && i < 5; i++) begin
            chk("lat_seq_data", out_dat[i], i + 1);
            chk("lat_seq_cycle", out_cyc[i], 3 + i);
        end

        // full DEPTH=2 with downstream stalled: exactly four beats accepted
        s_down_ready = 1'b0;
        s_up_valid   = 1'b1;
        s_up_data    = 16'h0100;
        acc_n = 0;
        fourth = -1;
        low_at = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            acc = s_up_ready;
            if (acc) begin
                acc_n++;
                if (acc_n == 4) fourth = c;
            end else if (low_at < 0) low_at = c;
            cyc();
            if (acc) s_up_data = s_up_data + 16'h1;
        end
        chk("cap_accepted", acc_n, 4);
        chk("cap_ready_low_at", low_at, 4);
        chk("cap_fourth_at", fourth, 3);
        chk("cap_occ", s_occ, 4);
        chk("cap_valid", s_down_valid, 1);
        chk("cap_head", s_down_data, 16'h0100);
        s_up_valid   = 1'b0;
        s_down_ready = 1'b1;
        repeat (8) cyc();
        chk("cap_drained", s_occ, 0);

        // forward DEPTH=3 full, then reset mid-cycle
        f_down_ready = 1'b0;
        f_up_valid   = 1'b1;
        repeat (5) begin
            f_up_data = DW'($urandom);
            cyc();
        end
        chk("rstmid_full_before", f_occ, 3);
        f_up_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_valid", f_down_valid, 0);
        chk("rstmid_occ", f_occ, 0);
        chk("rstmid_ready", f_up_ready, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        f_down_ready = 1'b1;
        @(negedge clk);
        chk("rstrel_ready_before_edge", f_up_ready, 0);
        cyc();
        chk("rstrel_ready_after_edge", f_up_ready, 1);
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (f_down_valid) stale++;
        end
        chk("rstrel_no_stale", stale, 0);

        // randomized traffic on all three, with isolation probes on the full chain
        for (int c = 0; c < 8000; c++) begin
            cyc();
            rp = (c / 1000) % 3;
            f_up_valid   = ($urandom_range(0, 9) < 7);
            f_up_data    = DW'($urandom);
            f_down_ready = ($urandom_range(0, 9) < (rp == 0 ? 2 : (rp == 1 ? 5 : 9)));
            s_up_valid   = ($urandom_range(0, 9) < 7);
            s_up_data    = DW'($urandom);
            s_down_ready = ($urandom_range(0, 9) < (rp == 0 ? 2 : (rp == 1 ? 5 : 9)));
            b_up_valid   = $urandom_range(0, 1);
            b_up_data    = DW'($urandom);
            b_down_ready = $urandom_range(0, 1);
            if (c % 16 == 0) begin
                @(negedge clk);
                #2;
                ur0 = s_up_ready; dv0 = s_down_valid; dd0 = s_down_data; oc0 = s_occ;
                s_down_ready = ~s_down_ready;
                s_up_valid   = ~s_up_valid;
                s_up_data    = ~s_up_data;
                #1;
                chk("iso_ready", s_up_ready, ur0);
                chk("iso_valid", s_down_valid, dv0);
                chk("iso_data", s_down_data, dd0);
                chk("iso_occ", s_occ, oc0);
                s_down_ready = ~s_down_ready;
                s_up_valid   = ~s_up_valid;
                s_up_data    = ~s_up_data;
            end
        end

        // full chain with downstream ready toggling 1010...
        f_up_valid = 1'b0;
        b_up_valid = 1'b0;
        f_down_ready = 1'b1;
        s_down_ready = 1'b1;
        repeat (8) cyc();
        s_up_valid = 1'b1;
        s_up_data  = 16'h0000;
        emits = 0;
        for (int c = 0; c < 420; c++) begin
            s_down_ready = (c % 2 == 0);
            @(negedge clk);
            acc = s_up_valid && s_up_ready;
            if (s_down_valid && s_down_ready) emits++;
            cyc();
            if (acc) s_up_data = s_up_data + 16'h1;
        end
        chk("toggle_emits", emits >= 200, 1);
        s_up_valid   = 1'b0;
        s_down_ready = 1'b1;
        repeat (10) cyc();
        chk("toggle_drained", s_occ, 0);
        chk("toggle_model_empty", q_full.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_slice_chain.md
REG_SLICE_CHAIN -- requirements
Module: reg_slice_chain

Interface
REQ-001 Parameter DW, default 16, payload width in bits (1..1024).
REQ-002 Parameter DEPTH, default 1, number of cascaded stages (1..8); ignored when MODE=2.
REQ-003 Parameter MODE, default 0: 0=forward (valid/data registered, ready combinational), 1=full (valid/data and ready all registered, skid buffer), 2=bypass (wires only).
REQ-004 Parameter CW, default $clog2(2*DEPTH+1), width of the occupancy output.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 up_valid  input  1  upstream beat present.
REQ-008 up_data  input  DW  upstream payload.
REQ-009 up_ready  output  1  chain accepts a beat this cycle.
REQ-010 down_valid  output  1  downstream beat present.
REQ-011 down_data  output  DW  downstream payload.
REQ-012 down_ready  input  1  downstream accepts a beat this cycle.
REQ-013 occupancy  output  CW  number of beats currently held in the chain.

Function
REQ-014 A transfer occurs on any edge where valid and ready are both high, at either port; no other condition moves a beat.
REQ-015 The chain shall preserve order, never duplicate or drop a beat, and deliver data bit-exact.
REQ-016 Stages shall be cascaded: stage k down port drives stage k+1 up port; stage 0 faces up_*, stage DEPTH-1 faces down_*.
REQ-017 MODE=0 stage: up_ready = !down_valid_reg || down_ready_in; on up_ready, valid_reg <= up_valid, and data_reg <= up_data only when up_valid is high; capacity 1 beat.
REQ-018 MODE=1 stage: holds main and skid registers, capacity 2; up_ready is a flop equal to "skid empty"; a beat arriving while main is full and downstream stalls goes to skid; on the next downstream transfer skid moves to main.
REQ-019 MODE=1: no combinational path from any down_ready to up_ready, nor from up_valid/up_data to any output.
REQ-020 MODE=2: up_ready = down_ready, down_valid = up_valid, down_data = up_data; occupancy constant 0.
REQ-021 Latency up_valid to down_valid with down_ready held high: DEPTH cycles in MODES 0 and 1, 0 cycles in MODE 2.
REQ-022 Throughput: one beat per cycle sustained when down_ready held high, all modes.
REQ-023 Capacity: DEPTH beats in MODE 0, 2*DEPTH beats in MODE 1; up_ready low exactly when the chain is at capacity and cannot advance (MODE 0) or stage-0 skid is full (MODE 1).
REQ-024 While down_valid is high and down_ready low, down_valid and down_data shall stay stable.
REQ-025 Simultaneous accept and emit in the same cycle shall leave occupancy unchanged.
REQ-026 occupancy = accepted beats minus emitted beats, updated every edge, never exceeding capacity.
REQ-027 Data registers shall not change on cycles without an incoming transfer into that register.

Reset
REQ-028 On rst high, asynchronously: all valid flags 0, all data registers 0, occupancy 0.
REQ-029 While rst is high, up_ready shall be 0 in MODES 0 and 1; it shall reach 1 on the first edge after release.
REQ-030 A beat in flight when rst asserts shall be discarded; no beat emitted after reset that was accepted before it.

Structure
REQ-031 MODE encodings (MODE_FWD=0, MODE_FULL=1, MODE_BYPASS=2) shall live in shared package reg_slice_pkg.
REQ-032 One stage shall be a sub-module reg_slice_stage (parameters DW, MODE), instantiated DEPTH times via generate; occupancy computed at top level.
REQ-033 An illegal MODE or DEPTH shall fail elaboration.

Verification
REQ-034 MODE=0, DEPTH=3, down_ready=1, beats 0x0001..0x0005 back-to-back -> first down_valid 3 cycles after first accept, all five in order, one per cycle.
REQ-035 MODE=1, DEPTH=2, down_ready=0, push continuously -> exactly 4 beats accepted, up_ready low from the edge after the 4th, occupancy=4, down_data=first beat and stable.
REQ-036 MODE=1, DEPTH=1, random up_valid/down_ready 10000 cycles -> scoreboard exact order, no loss, occupancy always 0..2.
REQ-037 MODE=2 -> down_* equal up_* combinationally each cycle, occupancy 0.
REQ-038 MODE=0, DEPTH=2, chain full, assert rst mid-cycle -> down_valid and occupancy 0 immediately, up_ready 0 during rst, 1 after release, no stale beat emitted.
REQ-039 MODE=1, DEPTH=4, down_ready toggling 1010..., 200 beats -> 100% order match, up_ready never depends combinationally on down_ready (formal/structural check).
